bsg_front_side_bus_hop_in_buffered: RTL and testbench

//  Flow-controlled successor to the no-flow-control FSB hop-in stage. Registers one FSB beat
//  per cycle and forwards every beat unconditionally to the next hop. Beats whose destination
//  ID matches this node, or the broadcast ID, are copied into a local buffer drained by a

---
 rtl/bsg_fsb_pkg.sv | 17 +
 rtl/bsg_front_side_bus_hop_in_buffered_local_fifo.sv | 72 +++++++
 rtl/bsg_front_side_bus_hop_in_buffered.sv | 101 ++++++++++
 tb/tb_bsg_front_side_bus_hop_in_buffered.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fsb_pkg.sv
// Shared front-side-bus definitions: default ID width, beat layout and broadcast ID.
package bsg_fsb_pkg;

  localparam int bsg_fsb_id_width_gp = 4;
  localparam int bsg_fsb_width_gp    = 64;

  typedef struct packed {
    logic [bsg_fsb_id_width_gp-1:0]                  id;
    logic [bsg_fsb_width_gp-bsg_fsb_id_width_gp-1:0] payload;
  } bsg_fsb_beat_s;

  // All-ones ID of the given width addresses every node.
  function automatic logic [31:0] bsg_fsb_broadcast_id(input int unsigned id_width);
    return (id_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << id_width) - 32'd1);
  endfunction

endpackage

// File: rtl/bsg_front_side_bus_hop_in_buffered_local_fifo.sv
// Circular local buffer for FSB hop-in: pointers, count, storage and the drop rule.
module bsg_fsb_hop_in_local_fifo #(
  parameter int width_p = 64,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               accept_o,
  output logic               drop_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [ptr_w_lp-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ptr_w_lp-1:0] rd_ptr_reg, rd_ptr_next;
  logic [cnt_w_lp-1:0] count_reg, count_next;
  logic [width_p-1:0]  mem [els_p];
  logic                full, empty, do_pop;

  assign full  = (count_reg == cnt_w_lp'(els_p));
  assign empty = (count_reg == '0);

  // A pop in the same cycle frees the head slot, so a push into a full buffer still lands.
  assign do_pop   = pop_i & ~empty;
  assign accept_o = push_i & (~full | do_pop);
  assign drop_o   = push_i & full & ~do_pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (accept_o)
      wr_ptr_next = (wr_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_reg + 1'b1;
    if (do_pop)
      rd_ptr_next = (rd_ptr_reg == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_reg + 1'b1;
    case ({accept_o, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset; stale slots are never visible because the head output is gated.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_slot
    always_ff @(posedge clk_i) begin
      if (accept_o && (wr_ptr_reg == ptr_w_lp'(gi)))
        mem[gi] <= data_i;
    end
  end

  assign v_o    = ~empty;
  assign data_o = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/bsg_front_side_bus_hop_in_buffered.sv
// FSB hop-in with local buffering and credit return. Optional counters: BSG_FSB_HOP_IN_STATS_EN.
module bsg_front_side_bus_hop_in_buffered
  import bsg_fsb_pkg::*;
#(
  parameter int width_p     = bsg_fsb_width_gp,
  parameter int id_width_p  = bsg_fsb_id_width_gp,
  parameter int local_els_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [width_p-1:0]    data_i,
  input  logic                  v_i,
  input  logic [id_width_p-1:0] node_id_i,
  output logic [width_p-1:0]    next_data_o,
  output logic                  next_v_o,
  output logic [width_p-1:0]    local_data_o,
  output logic                  local_v_o,
  input  logic                  local_yumi_i,
  output logic                  credit_o,
  output logic                  overflow_o
`ifdef BSG_FSB_HOP_IN_STATS_EN
  ,
  output logic [31:0]           hit_count_o,
  output logic [15:0]           drop_count_o
`endif
);

  localparam logic [id_width_p-1:0] broadcast_id_lp = id_width_p'(bsg_fsb_broadcast_id(id_width_p));

  logic                  v_reg;
  logic [width_p-1:0]    data_reg;
  logic                  credit_reg;
  logic                  overflow_reg;
  logic [id_width_p-1:0] id_field;
  logic                  hit, pop, accept, drop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_reg        <= 1'b0;
      data_reg     <= '0;
      credit_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      v_reg        <= v_i;
      data_reg     <= data_i;
      credit_reg   <= pop;
      overflow_reg <= overflow_reg | drop;
    end
  end

  assign id_field = data_reg[width_p-1 -: id_width_p];
  assign hit      = v_reg & ((id_field == node_id_i) | (id_field == broadcast_id_lp));
  // A yumi against an empty buffer is ignored and returns no credit.
  assign pop      = local_yumi_i & local_v_o;

  bsg_fsb_hop_in_local_fifo #(
    .width_p (width_p),
    .els_p   (local_els_p)
  ) local_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (hit),
    .data_i    (data_reg),
    .pop_i     (pop),
    .data_o    (local_data_o),
    .v_o       (local_v_o),
    .accept_o  (accept),
    .drop_o    (drop)
  );

  assign next_v_o    = v_reg;
  assign next_data_o = data_reg;
  assign credit_o    = credit_reg;
  assign overflow_o  = overflow_reg;

`ifdef BSG_FSB_HOP_IN_STATS_EN
  logic [31:0] hit_count_reg;
  logic [15:0] drop_count_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (accept) hit_count_reg  <= hit_count_reg + 32'd1;
      if (drop)   drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign hit_count_o  = hit_count_reg;
  assign drop_count_o = drop_count_reg;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    local_yumi_i |-> local_v_o)
    else $error("local_yumi_i asserted while local buffer empty");

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in_buffered.sv
// Randomized and directed bench for the FSB hop-in with a queue-based reference model.
module tb_bsg_front_side_bus_hop_in_buffered;

  localparam int ELS = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [63:0] data_i;
  logic        v_i;
  logic [3:0]  node_id_i;
  logic [63:0] next_data_o;
  logic        next_v_o;
  logic [63:0] local_data_o;
  logic        local_v_o;
  logic        local_yumi_i;
  logic        credit_o;
  logic        overflow_o;
`ifdef BSG_FSB_HOP_IN_STATS_EN
  logic [31:0] hit_count_o;
  logic [15:0] drop_count_o;
`endif

  bsg_front_side_bus_hop_in_buffered #(
    .width_p     (64),
    .id_width_p  (4),
    .local_els_p (ELS)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .data_i       (data_i),
    .v_i          (v_i),
    .node_id_i    (node_id_i),
    .next_data_o  (next_data_o),
    .next_v_o     (next_v_o),
    .local_data_o (local_data_o),
    .local_v_o    (local_v_o),
    .local_yumi_i (local_yumi_i),
    .credit_o     (credit_o),
    .overflow_o   (overflow_o)
`ifdef BSG_FSB_HOP_IN_STATS_EN
    ,
    .hit_count_o  (hit_count_o),
    .drop_count_o (drop_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: one-beat delay line plus a bounded queue of local beats.
  logic [63:0] q[$];
  logic        m_next_v;
  logic [63:0] m_next_data;
  logic        m_credit;
  logic        m_ovf;
  int unsigned m_hits, m_drops;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      q.delete();
      m_next_v = 0; m_next_data = '0; m_credit = 0; m_ovf = 0; m_hits = 0; m_drops = 0;
    end else begin
      logic is_hit;
      m_credit = local_yumi_i && (q.size() > 0);
      if (m_credit) void'(q.pop_front());
      is_hit = m_next_v && (m_next_data[63:60] == node_id_i || m_next_data[63:60] == 4'hF);
      if (is_hit) begin
        if (q.size() < ELS) begin
          q.push_back(m_next_data);
          m_hits++;
        end else begin
          m_ovf = 1;
          m_drops++;
        end
      end
      m_next_v = v_i;
      m_next_data = data_i;
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en && reset_n_i) begin
      cmp("next_v", 64'(next_v_o), 64'(m_next_v));
      cmp("next_data", next_data_o, m_next_data);
      cmp("local_v", 64'(local_v_o), 64'(q.size() > 0));
      if (q.size() > 0) cmp("local_data", local_data_o, q[0]);
      cmp("credit", 64'(credit_o), 64'(m_credit));
      cmp("overflow", 64'(overflow_o), 64'(m_ovf));
`ifdef BSG_FSB_HOP_IN_STATS_EN
      cmp("hit_count", 64'(hit_count_o), 64'(m_hits));
      cmp("drop_count", 64'(drop_count_o), 64'(m_drops[15:0]));
`endif
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic y);
    v_i = v; data_i = d; local_yumi_i = y;
    @(negedge clk_i);
    $display("cyc t=%0t v=%0b d=%h yumi=%0b next_v=%0b local_v=%0b credit=%0b ovf=%0b",
             $time, v, d, y, next_v_o, local_v_o, credit_o, overflow_o);
  endtask

  task automatic do_reset();
    v_i = 0; data_i = '0; local_yumi_i = 0;
    @(negedge clk_i); #2 reset_n_i = 0;
    @(negedge clk_i); #2 reset_n_i = 1;
    @(negedge clk_i);
  endtask

  function automatic logic [63:0] beat(input logic [3:0] id, input int unsigned n);
    return {id, 28'h0, 32'(n) ^ 32'hA5A5_0000};
  endfunction

  logic [63:0] b [5];
  int          credits;

  initial begin
    reset_n_i = 0; v_i = 0; data_i = '0; local_yumi_i = 0; node_id_i = 4'h3;
    repeat (2) @(negedge clk_i);
    #2 reset_n_i = 1;
    @(negedge clk_i);
    chk_en = 1;
    cmp("reset_local_v", 64'(local_v_o), 64'd0);
    cmp("reset_overflow", 64'(overflow_o), 64'd0);

    // Unicast hit: forward after 1 cycle, buffered after 2, credit after pop.
    b[0] = beat(4'h3, 1);
    step(1, b[0], 0);
    cmp("t2_next_v", 64'(next_v_o), 64'd1);
    cmp("t2_next_data", next_data_o, b[0]);
    cmp("t2_local_v_early", 64'(local_v_o), 64'd0);
    step(0, '0, 0);
    cmp("t2_local_v", 64'(local_v_o), 64'd1);
    cmp("t2_local_data", local_data_o, b[0]);
    step(0, '0, 1);
    cmp("t2_credit", 64'(credit_o), 64'd1);
    step(0, '0, 0);
    cmp("t2_credit_off", 64'(credit_o), 64'd0);

    // Miss is forwarded only; broadcast is forwarded and buffered.
    step(1, beat(4'h5, 2), 0);
    cmp("t3_miss_fwd", 64'(next_v_o), 64'd1);
    step(0, '0, 0);
    cmp("t3_miss_local", 64'(local_v_o), 64'd0);
    step(1, beat(4'hF, 3), 0);
    cmp("t3_bc_fwd", 64'(next_v_o), 64'd1);
    step(0, '0, 0);
    cmp("t3_bc_local", local_data_o, beat(4'hF, 3));
    step(0, '0, 1);

    // Five hits into a four-deep buffer: fifth dropped.
    for (int i = 0; i < 5; i++) begin
      b[i] = beat(4'h3, 10 + i);
      step(1, b[i], 0);
    end
    step(0, '0, 0);
    cmp("t4_overflow", 64'(overflow_o), 64'd1);
`ifdef BSG_FSB_HOP_IN_STATS_EN
    cmp("t4_drop_count", 64'(drop_count_o), 64'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      cmp("t4_order", local_data_o, b[i]);
      step(0, '0, 1);
    end
    cmp("t4_empty", 64'(local_v_o), 64'd0);

    // Asynchronous reset mid-stream with three beats buffered.
    for (int i = 0; i < 3; i++) step(1, beat(4'h3, 20 + i), 0);
    step(1, beat(4'h5, 23), 0);
    #2 reset_n_i = 0;
    #1;
    cmp("t1_next_v", 64'(next_v_o), 64'd0);
    cmp("t1_next_data", next_data_o, 64'd0);
    cmp("t1_local_v", 64'(local_v_o), 64'd0);
    cmp("t1_local_data", local_data_o, 64'd0);
    cmp("t1_credit", 64'(credit_o), 64'd0);
    cmp("t1_overflow", 64'(overflow_o), 64'd0);
    v_i = 0; data_i = '0;
    @(negedge clk_i); #2 reset_n_i = 1;
    step(0, '0, 0);
    cmp("t1_post_local_v", 64'(local_v_o), 64'd0);
    cmp("t1_post_credit", 64'(credit_o), 64'd0);

    // Full buffer with simultaneous hit and pop: no drop.
    for (int i = 0; i < 5; i++) begin
      b[i] = beat(4'h3, 30 + i);
      step(1, b[i], 0);
    end
    step(0, '0, 1);
    cmp("t5_credit", 64'(credit_o), 64'd1);
    cmp("t5_overflow", 64'(overflow_o), 64'd0);
    for (int i = 1; i < 5; i++) begin
      cmp("t5_order", local_data_o, b[i]);
      step(0, '0, 1);
    end
    cmp("t5_empty", 64'(local_v_o), 64'd0);

    // Random traffic with a credit-obeying upstream.
    do_reset();
    credits = ELS;
    for (int i = 0; i < 10000; i++) begin
      logic [3:0]  id;
      logic        v, y;
      if (credit_o) credits++;
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0: id = 4'h3;
        1: id = 4'hF;
        default: id = 4'($urandom_range(0, 14));
      endcase
      if (v && (id == 4'h3 || id == 4'hF)) begin
        if (credits > 0) credits--;
        else id = 4'h5;
      end
      y = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      step(v, {id, 28'($urandom), $urandom}, y);
    end
    for (int i = 0; i < 8; i++) step(0, '0, q.size() > 0);
    cmp("t6_overflow", 64'(overflow_o), 64'd0);
    cmp("t6_drained", 64'(local_v_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
